// File: rtl/adaptive_thr_pkg.sv
// Shared types and base target bands for the multi-octave adaptive threshold controller.
package adaptive_thr_pkg;

  typedef enum logic [1:0] {
    MODE_HT     = 2'd0,
    MODE_HA     = 2'd1,
    MODE_BAL    = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_DOWN = 2'd1,
    PEND_UP   = 2'd2
  } pend_e;

  localparam int LO_HT  = 500;
  localparam int HI_HT  = 1000;
  localparam int LO_HA  = 1500;
  localparam int HI_HA  = 2000;
  localparam int LO_BAL = 1000;
  localparam int HI_BAL = 1500;

  function automatic logic [31:0] band_lo(input mode_e m);
    case (m)
      MODE_HT:  return 32'(LO_HT);
      MODE_HA:  return 32'(LO_HA);
      MODE_BAL: return 32'(LO_BAL);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] band_hi(input mode_e m);
    case (m)
      MODE_HT:  return 32'(HI_HT);
      MODE_HA:  return 32'(HI_HA);
      MODE_BAL: return 32'(HI_BAL);
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/adaptive_thr_oct_cnt.sv
// Per-octave saturating keypoint counter with end-of-frame shadow snapshot.
module adaptive_thr_oct_cnt #(
  parameter int KP_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            snap,
  output logic [KP_W-1:0] shadow
);

  localparam logic [KP_W-1:0] ONE = KP_W'(1);

  logic [KP_W-1:0] cnt;
  logic [KP_W-1:0] cnt_next;

  // The keypoint arriving with the snapshot still belongs to the ending frame.
  assign cnt_next = (inc && (cnt != '1)) ? cnt + ONE : cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (snap) begin
      shadow <= cnt_next;
      cnt    <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/adaptive_threshold_ctrl.sv
// Multi-octave adaptive contrast threshold controller; one shared step/clamp unit walks the octaves.
// Build option: define ADAPT_HYST_EN to require two consecutive same-direction frames per step.
module adaptive_threshold_ctrl
  import adaptive_thr_pkg::*;
#(
  parameter int NUM_OCT  = 4,
  parameter int THR_W    = 10,
  parameter int KP_W     = 12,
  parameter int THR_INIT = 2,
  parameter int THR_MIN  = -32,
  parameter int THR_MAX  = 127,
  parameter int STEP     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic                         kp_valid,
  input  logic [$clog2(NUM_OCT)-1:0]   kp_oct,
  input  logic                         frame_end,
  output logic [NUM_OCT*THR_W-1:0]     thr_out,
  output logic                         thr_update,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(NUM_OCT);
  localparam logic signed [THR_W:0]   MIN_W  = (THR_W+1)'(THR_MIN);
  localparam logic signed [THR_W:0]   MAX_W  = (THR_W+1)'(THR_MAX);
  localparam logic signed [THR_W:0]   STEP_W = (THR_W+1)'(STEP);
  localparam logic signed [THR_W-1:0] MIN_N  = THR_W'(THR_MIN);
  localparam logic signed [THR_W-1:0] MAX_N  = THR_W'(THR_MAX);
  localparam logic signed [THR_W-1:0] INIT_N = THR_W'(THR_INIT);
  localparam logic [IDX_W-1:0]        LAST   = IDX_W'(NUM_OCT - 1);

  state_e                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [THR_W-1:0]  thr    [NUM_OCT];
  logic [KP_W-1:0]          shadow [NUM_OCT];
  logic                     snap;

  assign snap = frame_end && (state == ST_COUNT);

  for (genvar g = 0; g < NUM_OCT; g++) begin : g_oct
    adaptive_thr_oct_cnt #(.KP_W(KP_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (kp_valid && (kp_oct == IDX_W'(g))),
      .snap   (snap),
      .shadow (shadow[g])
    );
    assign thr_out[g*THR_W +: THR_W] = thr[g];
  end

  // Shared comparator/clamp unit for the octave selected by idx.
  mode_e                    cur_mode;
  logic [31:0]              sh_ext, lo_o, hi_o;
  logic                     below, above, apply_dn, apply_up;
  logic signed [THR_W-1:0]  cur, dec_sat, inc_sat, next_thr;
  logic signed [THR_W:0]    cur_w, dec_w, inc_w;

`ifdef ADAPT_HYST_EN
  pend_e pend [NUM_OCT];
`endif

  always_comb begin
    cur_mode = mode_e'(mode);
    sh_ext   = {{(32-KP_W){1'b0}}, shadow[idx]};
    lo_o     = band_lo(cur_mode) >> idx;
    hi_o     = band_hi(cur_mode) >> idx;
    below    = (cur_mode != MODE_FREEZE) && (sh_ext < lo_o);
    above    = (cur_mode != MODE_FREEZE) && !below && (sh_ext > hi_o);
    cur      = thr[idx];
    cur_w    = {cur[THR_W-1], cur};
    dec_w    = cur_w - STEP_W;
    inc_w    = cur_w + STEP_W;
    dec_sat  = (dec_w < MIN_W) ? MIN_N : dec_w[THR_W-1:0];
    inc_sat  = (inc_w > MAX_W) ? MAX_N : inc_w[THR_W-1:0];
`ifdef ADAPT_HYST_EN
    apply_dn = below && (pend[idx] == PEND_DOWN);
    apply_up = above && (pend[idx] == PEND_UP);
`else
    apply_dn = below;
    apply_up = above;
`endif
    next_thr = apply_dn ? dec_sat : (apply_up ? inc_sat : cur);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_COUNT;
      idx        <= '0;
      busy       <= 1'b0;
      thr_update <= 1'b0;
      overrun    <= 1'b0;
      for (int o = 0; o < NUM_OCT; o++) begin
        thr[o] <= INIT_N;
`ifdef ADAPT_HYST_EN
        pend[o] <= PEND_NONE;
`endif
      end
    end else begin
      thr_update <= 1'b0;
      if (frame_end && (state != ST_COUNT)) overrun <= 1'b1;
      case (state)
        ST_COUNT: begin
          if (frame_end) begin
            state <= ST_UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_UPDATE: begin
          thr[idx] <= next_thr;
`ifdef ADAPT_HYST_EN
          if (apply_dn || apply_up || !(below || above)) pend[idx] <= PEND_NONE;
          else if (below)                                pend[idx] <= PEND_DOWN;
          else                                           pend[idx] <= PEND_UP;
`endif
          if (idx == LAST) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            thr_update <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= ST_COUNT;
      endcase
      // Disabled: every lane pinned to the init value, overriding any update write.
      if (!enable) begin
        for (int o = 0; o < NUM_OCT; o++) begin
          thr[o] <= INIT_N;
`ifdef ADAPT_HYST_EN
          pend[o] <= PEND_NONE;
`endif
        end
      end
    end
  end

endmodule
